// File: rtl/matrix_result_writer.sv
// Responder end of the matrix-op result-write handshake: latches a result header, writes the
// metadata words, then commits the streamed elements row-major into the matrix's storage block.
module matrix_result_writer #(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned META_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  write_ready,
  input  logic                  write_request,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [7:0]            matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam int unsigned Capacity = BLOCK_SIZE - META_WORDS;

  typedef enum logic [2:0] {StIdle, StCheck, StMeta, StData, StDone} state_e;

  function automatic logic [31:0] encode_shape_word(input logic [7:0] rows,
                                                     input logic [7:0] cols);
    return {16'h0000, rows, cols};
  endfunction

  // Returns {rows, cols}.
  function automatic logic [15:0] decode_shape_word(input logic [31:0] word);
    return word[15:0];
  endfunction

  state_e state_q, state_d;

  logic [2:0]            id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [7:0]            name_q [0:7];
  logic                  err_q, err_d;
  logic [15:0]           meta_idx_q, meta_idx_d;
  logic [15:0]           elem_idx_q, elem_idx_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  hdr_load;
  logic                  xfer;
  logic                  reject;
  logic [15:0]           total;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [31:0]           meta_word;

  assign total     = {8'h00, rows_q} * {8'h00, cols_q};
  assign reject    = (rows_q == 8'd0) || (cols_q == 8'd0) || (32'(total) > Capacity);
  assign base_addr = ADDR_WIDTH'(32'(id_q) * BLOCK_SIZE);
  assign hdr_load  = (state_q == StIdle) && write_request;
  assign xfer      = (state_q == StData) && data_valid;

  always_comb begin
    case (meta_idx_q)
      16'd0:   meta_word = encode_shape_word(rows_q, cols_q);
      16'd1:   meta_word = {name_q[3], name_q[2], name_q[1], name_q[0]};
      16'd2:   meta_word = {name_q[7], name_q[6], name_q[5], name_q[4]};
      default: meta_word = 32'h0000_0000;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (write_request) state_d = StCheck;
      StCheck: state_d = reject ? StDone : StMeta;
      StMeta:  if (meta_idx_q == 16'(META_WORDS - 1)) state_d = StData;
      StData:  if (xfer && (elem_idx_q == total - 16'd1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    write_ready  = (state_q == StIdle);
    writer_ready = (state_q == StData);
    busy         = (state_q != StIdle);
    write_done   = (state_q == StDone);
    write_error  = (state_q == StDone) && err_q;

    err_d       = err_q;
    meta_idx_d  = meta_idx_q;
    elem_idx_d  = elem_idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (write_request) begin
          err_d      = 1'b0;
          meta_idx_d = 16'd0;
          elem_idx_d = 16'd0;
        end
      end
      StCheck: err_d = reject;
      StMeta: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = base_addr + ADDR_WIDTH'(meta_idx_q);
        mem_wdata_d = DATA_WIDTH'(meta_word);
        meta_idx_d  = meta_idx_q + 16'd1;
      end
      StData: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_addr + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(elem_idx_q);
          mem_wdata_d = data_in;
          elem_idx_d  = elem_idx_q + 16'd1;
        end
      end
      StDone:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      for (int k = 0; k < 8; k++) name_q[k] <= '0;
      err_q       <= 1'b0;
      meta_idx_q  <= '0;
      elem_idx_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (hdr_load) begin
        id_q   <= matrix_id;
        rows_q <= actual_rows;
        cols_q <= actual_cols;
        for (int k = 0; k < 8; k++) name_q[k] <= matrix_name[k];
      end
      err_q       <= err_d;
      meta_idx_q  <= meta_idx_d;
      elem_idx_q  <= elem_idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  shape_roundtrip: assert property (@(posedge clk) disable iff (!rst_n)
    decode_shape_word(encode_shape_word(rows_q, cols_q)) == {rows_q, cols_q});

endmodule
